// File: rtl/ahb3lite_apb_bridge.sv
// ============================================================================
// Module   : ahb3lite_apb_bridge
// Brief    : AHB3-Lite slave that turns each accepted transfer into one APB4
//            transfer. Single shared clock, one transfer in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb3lite_apb_bridge #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  // AHB3-Lite slave side
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  output logic                  HREADYOUT,
  input  logic                  HREADY,
  output logic                  HRESP,
  // APB4 master side
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [2:0]            PPROT,
  output logic                  PWRITE,
  output logic [3:0]            PSTRB,
  output logic [PADDR_SIZE-1:0] PADDR,
  output logic [HDATA_SIZE-1:0] PWDATA,
  input  logic [HDATA_SIZE-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WDATA  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic                  w_accept;
  logic                  w_size_err;
  logic [3:0]            w_pstrb;
  logic                  w_apb_done;
  logic                  w_unused;

  logic                  r_pwrite;
  logic [2:0]            r_pprot;
  logic [3:0]            r_pstrb;
  logic [PADDR_SIZE-1:0] r_paddr;
  logic [HDATA_SIZE-1:0] r_pwdata;
  logic [HDATA_SIZE-1:0] r_hrdata;

  // Burst/lock attributes carry no meaning here: every beat stands alone.
  assign w_unused = ^{HBURST, HMASTLOCK, HTRANS[0], HPROT[3:2],
                      HADDR[HADDR_SIZE-1:PADDR_SIZE]};

  assign w_accept   = HSEL & HREADY & HTRANS[1] &
                      ((r_state == S_IDLE) | (r_state == S_ERR2));
  assign w_size_err = (HSIZE > 3'b010);
  assign w_apb_done = (r_state == S_ACCESS) & PREADY;

  always_comb begin
    w_pstrb = 4'h0;
    if (HWRITE) begin
      case (HSIZE[1:0])
        2'b00:   w_pstrb = 4'b0001 << HADDR[1:0];
        2'b01:   w_pstrb = 4'b0011 << {HADDR[1], 1'b0};
        default: w_pstrb = 4'hF;
      endcase
    end
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ERR2: begin
        if (w_accept) begin
          if (w_size_err)  w_state_nxt = S_ERR1;
          else if (HWRITE) w_state_nxt = S_WDATA;
          else             w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WDATA:  w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) w_state_nxt = PSLVERR ? S_ERR1 : S_IDLE;
      end
      S_ERR1:   w_state_nxt = S_ERR2;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (r_state)
      S_WDATA:  HREADYOUT = 1'b0;
      S_SETUP:  begin HREADYOUT = 1'b0; PSEL = 1'b1; end
      S_ACCESS: begin HREADYOUT = 1'b0; PSEL = 1'b1; PENABLE = 1'b1; end
      S_ERR1:   begin HREADYOUT = 1'b0; HRESP = 1'b1; end
      S_ERR2:   HRESP = 1'b1;
      default:  ;
    endcase
  end

  // Address-phase attributes are frozen at accept and held through ACCESS.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pwrite <= 1'b0;
      r_pprot  <= 3'b000;
      r_pstrb  <= 4'h0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_hrdata <= '0;
    end else begin
      if (w_accept) begin
        r_pwrite <= HWRITE;
        r_pprot  <= {~HPROT[0], 1'b0, HPROT[1]};
        r_pstrb  <= w_pstrb;
        r_paddr  <= HADDR[PADDR_SIZE-1:0];
      end
      if (r_state == S_WDATA) r_pwdata <= HWDATA;
      if (w_apb_done && !PSLVERR && !r_pwrite) r_hrdata <= PRDATA;
    end
  end

  assign PWRITE = r_pwrite;
  assign PPROT  = r_pprot;
  assign PSTRB  = r_pstrb;
  assign PADDR  = r_paddr;
  assign PWDATA = r_pwdata;
  assign HRDATA = r_hrdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb3lite_apb_bridge.sv
// ============================================================================
// Module   : tb_ahb3lite_apb_bridge
// Brief    : Directed self-checking bench for the AHB3-Lite to APB4 bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb3lite_apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL, HWRITE, HMASTLOCK, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, HRESP;
  logic        PSEL, PENABLE, PWRITE;
  logic [2:0]  PPROT;
  logic [7:0]  PADDR;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  // Single-slave system: the bus HREADY is this slave's own HREADYOUT.
  assign HREADY = HREADYOUT;

  ahb3lite_apb_bridge #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(8)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADYOUT(HREADYOUT),
    .HREADY(HREADY), .HRESP(HRESP),
    .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Drive one address phase in the current cycle, then run the data phase
  // until HREADYOUT returns high. PREADY is held low for 'lows' ACCESS cycles.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [3:0] prot, input logic [31:0] wdata, input int lows,
                      input logic slverr, input logic [7:0] exp_paddr,
                      input logic [3:0] exp_pstrb, output int waits, output int psel_n,
                      output int bad, output int err1);
    int acc;
    acc = 0; waits = 0; psel_n = 0; bad = 0; err1 = 0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    HPROT = prot; HWDATA = ~wdata;
    step();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    while (HREADYOUT === 1'b0 && waits < 50) begin
      waits++;
      if (HRESP === 1'b1) err1 = 1;
      if (PSEL === 1'b1) begin
        psel_n++;
        if (PADDR !== exp_paddr || PSTRB !== exp_pstrb || PWRITE !== wr ||
            (wr && PWDATA !== wdata))
          bad++;
      end
      if (PENABLE === 1'b1) begin
        PREADY = (acc >= lows);
        acc++;
      end else begin
        PREADY = 1'b0;
      end
      PSLVERR = slverr;
      step();
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  int w, p, b, e;

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HMASTLOCK = 1'b0;
    HADDR = '0; HWDATA = '0; HSIZE = 3'b010; HBURST = 3'b000; HPROT = 4'b0011;
    HTRANS = 2'b00; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) step();

    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hresp",     {31'd0, HRESP},     32'd0);
    check("rst_hrdata",    HRDATA,             32'd0);
    check("rst_psel_pen",  {30'd0, PSEL, PENABLE}, 32'd0);
    check("rst_pwrite",    {31'd0, PWRITE},    32'd0);
    check("rst_pprot",     {29'd0, PPROT},     32'd0);
    check("rst_paddr",     {24'd0, PADDR},     32'd0);
    check("rst_pstrb",     {28'd0, PSTRB},     32'd0);
    check("rst_pwdata",    PWDATA,             32'd0);
    HRESETn = 1'b1;
    step();

    // Single word read, data-privileged (PPROT 3'b001)
    PRDATA = 32'hDEAD_BEEF;
    xfer(32'h0000_0024, 1'b0, 3'b010, 4'b0011, 32'h0, 0, 1'b0, 8'h24, 4'h0, w, p, b, e);
    check("rd_waits",   w, 2);
    check("rd_psel",    p, 2);
    check("rd_stable",  b, 0);
    check("rd_hrdata",  HRDATA, 32'hDEAD_BEEF);
    check("rd_resp",    {30'd0, HREADYOUT, HRESP}, 32'b10);
    check("rd_pprot",   {29'd0, PPROT}, 32'b001);

    // Byte write to lane 3, instruction-privileged (PPROT 3'b101)
    PRDATA = 32'h0BAD_0BAD;
    xfer(32'h0000_0013, 1'b1, 3'b000, 4'b0010, 32'hAABB_CCDD, 0, 1'b0, 8'h13, 4'b1000, w, p, b, e);
    check("wrb_waits",  w, 3);
    check("wrb_psel",   p, 2);
    check("wrb_stable", b, 0);
    check("wrb_pwdata", PWDATA, 32'hAABB_CCDD);
    check("wrb_pprot",  {29'd0, PPROT}, 32'b101);
    check("wrb_hrdata", HRDATA, 32'hDEAD_BEEF);

    // Halfword write to upper half; upper HADDR bits dropped from PADDR
    xfer(32'h0000_0102, 1'b1, 3'b001, 4'b0011, 32'h1234_5678, 0, 1'b0, 8'h02, 4'b1100, w, p, b, e);
    check("wrh_waits",  w, 3);
    check("wrh_stable", b, 0);
    check("wrh_resp",   {31'd0, HRESP}, 32'd0);

    // Read with PREADY low for four ACCESS cycles
    PRDATA = 32'h8765_4321;
    xfer(32'h0000_0040, 1'b0, 3'b010, 4'b0011, 32'h0, 4, 1'b0, 8'h40, 4'h0, w, p, b, e);
    check("ws_waits",   w, 6);
    check("ws_psel",    p, 6);
    check("ws_stable",  b, 0);
    check("ws_hrdata",  HRDATA, 32'h8765_4321);

    // Slave error: ERR1 then ERR2, HRDATA untouched, then IDLE
    PRDATA = 32'hFFFF_0000;
    xfer(32'h0000_0008, 1'b0, 3'b010, 4'b0011, 32'h0, 1, 1'b1, 8'h08, 4'h0, w, p, b, e);
    check("se_waits",   w, 4);
    check("se_err1",    e, 1);
    check("se_err2",    {30'd0, HREADYOUT, HRESP}, 32'b11);
    check("se_hrdata",  HRDATA, 32'h8765_4321);
    step();
    check("se_idle",    {30'd0, HREADYOUT, HRESP}, 32'b10);
    PRDATA = 32'hCAFE_F00D;
    xfer(32'h0000_000C, 1'b0, 3'b010, 4'b0011, 32'h0, 0, 1'b0, 8'h0C, 4'h0, w, p, b, e);
    check("se_next_waits", w, 2);
    check("se_next_data",  HRDATA, 32'hCAFE_F00D);
    check("se_next_resp",  {31'd0, HRESP}, 32'd0);

    // Size error: no APB cycle, then a read accepted straight from ERR2
    xfer(32'h0000_0010, 1'b0, 3'b011, 4'b0011, 32'h0, 0, 1'b0, 8'h10, 4'h0, w, p, b, e);
    check("sz_waits",   w, 1);
    check("sz_psel",    p, 0);
    check("sz_err1",    e, 1);
    check("sz_err2",    {30'd0, HREADYOUT, HRESP}, 32'b11);
    PRDATA = 32'h5555_AAAA;
    xfer(32'h0000_0030, 1'b0, 3'b010, 4'b0011, 32'h0, 0, 1'b0, 8'h30, 4'h0, w, p, b, e);
    check("err2_acc_waits", w, 2);
    check("err2_acc_data",  HRDATA, 32'h5555_AAAA);

    // IDLE and BUSY with HSEL high: zero-wait OKAY, no APB activity
    for (int t = 0; t < 2; t++) begin
      HSEL = 1'b1; HTRANS = (t == 0) ? 2'b00 : 2'b01; HADDR = 32'h44;
      step();
      check("idlebusy_resp", {29'd0, HREADYOUT, HRESP, PSEL}, 32'b100);
    end
    HSEL = 1'b0; HTRANS = 2'b00;

    // Back-to-back write then read: read SETUP right after write completes
    xfer(32'h0000_0050, 1'b1, 3'b010, 4'b0011, 32'h0F0F_0F0F, 0, 1'b0, 8'h50, 4'hF, w, p, b, e);
    check("b2b_wr_waits", w, 3);
    PRDATA = 32'h1357_9BDF;
    xfer(32'h0000_0054, 1'b0, 3'b010, 4'b0011, 32'h0, 0, 1'b0, 8'h54, 4'h0, w, p, b, e);
    check("b2b_rd_waits", w, 2);
    check("b2b_rd_psel",  p, 2);
    check("b2b_rd_data",  HRDATA, 32'h1357_9BDF);

    // Reset asserted during ACCESS drops PSEL without waiting for a clock
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h60; HWRITE = 1'b0; HSIZE = 3'b010;
    step();
    HSEL = 1'b0; HTRANS = 2'b00; PREADY = 1'b0;
    step();
    check("mid_access", {30'd0, PSEL, PENABLE}, 32'b11);
    #2 HRESETn = 1'b0;
    #1;
    check("rst_mid_psel",   {30'd0, PSEL, PENABLE}, 32'd0);
    check("rst_mid_ready",  {30'd0, HREADYOUT, HRESP}, 32'b10);
    check("rst_mid_paddr",  {24'd0, PADDR}, 32'd0);
    check("rst_mid_hrdata", HRDATA, 32'd0);
    check("rst_mid_pwdata", PWDATA, 32'd0);
    step();
    HRESETn = 1'b1;
    step();
    check("post_rst_idle", {29'd0, HREADYOUT, HRESP, PSEL}, 32'b100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
